// File: rtl/reg_file.sv
// RV32I integer register file: x0 hardwired to zero, one write port,
// two combinational read ports with same-cycle write-to-read bypass.
module reg_file #(
  parameter int REG_NUM    = 32,
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_enable_i,
  input  logic [ADDR_WIDTH-1:0] w_addr_i,
  input  logic [REG_WIDTH-1:0]  w_data_i,
  input  logic                  r1_read_i,
  input  logic [ADDR_WIDTH-1:0] r1_addr_i,
  output logic [REG_WIDTH-1:0]  r1_data_o,
  input  logic                  r2_read_i,
  input  logic [ADDR_WIDTH-1:0] r2_addr_i,
  output logic [REG_WIDTH-1:0]  r2_data_o
);

  logic [REG_WIDTH-1:0] r_regs [REG_NUM];
  logic                 w_wr_valid;

  assign w_wr_valid = w_enable_i && (w_addr_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_valid) begin
      r_regs[w_addr_i] <= w_data_i;
    end
  end

  // Bypass is only reachable for non-zero addresses, so x0 can never
  // observe in-flight write data.
  always_comb begin
    r1_data_o = '0;
    if (rst_n && r1_read_i && (r1_addr_i != '0)) begin
      if (w_enable_i && (w_addr_i == r1_addr_i)) begin
        r1_data_o = w_data_i;
      end else begin
        r1_data_o = r_regs[r1_addr_i];
      end
    end
  end

  always_comb begin
    r2_data_o = '0;
    if (rst_n && r2_read_i && (r2_addr_i != '0)) begin
      if (w_enable_i && (w_addr_i == r2_addr_i)) begin
        r2_data_o = w_data_i;
      end else begin
        r2_data_o = r_regs[r2_addr_i];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed-vector bench for reg_file: reset, basic access, x0 protection,
// bypass, port independence with overwrite, and asynchronous reset mid-run.
module tb_reg_file;

  localparam int RN = 32;
  localparam int RW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          w_enable_i;
  logic [AW-1:0] w_addr_i;
  logic [RW-1:0] w_data_i;
  logic          r1_read_i;
  logic [AW-1:0] r1_addr_i;
  logic [RW-1:0] r1_data_o;
  logic          r2_read_i;
  logic [AW-1:0] r2_addr_i;
  logic [RW-1:0] r2_data_o;

  int unsigned vectors;
  int unsigned miscompares;

  reg_file #(.REG_NUM(RN), .REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .w_enable_i (w_enable_i),
    .w_addr_i   (w_addr_i),
    .w_data_i   (w_data_i),
    .r1_read_i  (r1_read_i),
    .r1_addr_i  (r1_addr_i),
    .r1_data_o  (r1_data_o),
    .r2_read_i  (r2_read_i),
    .r2_addr_i  (r2_addr_i),
    .r2_data_o  (r2_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n      = 1'b0;
    w_enable_i = 1'b1;
    w_addr_i   = 5'd9;
    w_data_i   = 32'h5555_5555;
    r1_read_i  = 1'b1;
    r2_read_i  = 1'b1;
    for (int a = 0; a < RN; a++) begin
      @(negedge clk);
      r1_addr_i = AW'(a);
      r2_addr_i = AW'(RN - 1 - a);
      #1;
      vectors++;
      if (r1_data_o !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_r1 addr=%0d got %h exp %h", a, r1_data_o, 32'h0);
      end
      vectors++;
      if (r2_data_o !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_r2 addr=%0d got %h exp %h", RN - 1 - a, r2_data_o, 32'h0);
      end
    end
    @(negedge clk);
    w_enable_i = 1'b0;
    rst_n      = 1'b1;
    r1_addr_i  = 5'd9;
    r2_addr_i  = 5'd9;
    @(negedge clk);
    #1;
    vectors++;
    if (r1_data_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_write_ignored got %h exp %h", r1_data_o, 32'h0);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    w_enable_i = 1'b1;
    w_addr_i   = 5'd5;
    w_data_i   = 32'hDEAD_BEEF;
    r1_read_i  = 1'b0;
    r2_read_i  = 1'b0;
    @(negedge clk);
    w_enable_i = 1'b0;
    r1_addr_i  = 5'd5;
    r1_read_i  = 1'b1;
    #1;
    vectors++;
    if (r1_data_o !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL basic_read got %h exp %h", r1_data_o, 32'hDEAD_BEEF);
    end
    r1_read_i = 1'b0;
    #1;
    vectors++;
    if (r1_data_o !== 32'h0) begin
      miscompares++;
      $display("FAIL basic_read_disabled got %h exp %h", r1_data_o, 32'h0);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    w_enable_i = 1'b1;
    w_addr_i   = 5'd0;
    w_data_i   = 32'hFFFF_FFFF;
    r1_addr_i  = 5'd0;
    r2_addr_i  = 5'd0;
    r1_read_i  = 1'b1;
    r2_read_i  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if (r1_data_o !== 32'h0) begin
        miscompares++;
        $display("FAIL x0_r1 cycle=%0d got %h exp %h", c, r1_data_o, 32'h0);
      end
      vectors++;
      if (r2_data_o !== 32'h0) begin
        miscompares++;
        $display("FAIL x0_r2 cycle=%0d got %h exp %h", c, r2_data_o, 32'h0);
      end
      @(negedge clk);
      w_enable_i = 1'b0;
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    w_enable_i = 1'b1;
    w_addr_i   = 5'd7;
    w_data_i   = 32'h1111_1111;
    r1_read_i  = 1'b0;
    r2_read_i  = 1'b0;
    @(negedge clk);
    w_data_i  = 32'h2222_2222;
    r1_addr_i = 5'd7;
    r2_addr_i = 5'd7;
    r1_read_i = 1'b1;
    r2_read_i = 1'b1;
    #1;
    vectors++;
    if (r1_data_o !== 32'h2222_2222) begin
      miscompares++;
      $display("FAIL bypass_r1_pre got %h exp %h", r1_data_o, 32'h2222_2222);
    end
    vectors++;
    if (r2_data_o !== 32'h2222_2222) begin
      miscompares++;
      $display("FAIL bypass_r2_pre got %h exp %h", r2_data_o, 32'h2222_2222);
    end
    @(negedge clk);
    w_enable_i = 1'b0;
    #1;
    vectors++;
    if (r1_data_o !== 32'h2222_2222) begin
      miscompares++;
      $display("FAIL bypass_r1_post got %h exp %h", r1_data_o, 32'h2222_2222);
    end
    vectors++;
    if (r2_data_o !== 32'h2222_2222) begin
      miscompares++;
      $display("FAIL bypass_r2_post got %h exp %h", r2_data_o, 32'h2222_2222);
    end
    // write to a different address must not bypass onto x7 reads
    w_enable_i = 1'b1;
    w_addr_i   = 5'd8;
    w_data_i   = 32'h3333_3333;
    #1;
    vectors++;
    if (r1_data_o !== 32'h2222_2222) begin
      miscompares++;
      $display("FAIL bypass_other_addr got %h exp %h", r1_data_o, 32'h2222_2222);
    end
    @(negedge clk);
    w_enable_i = 1'b0;
  endtask

  task automatic test_ports_overwrite();
    logic [AW-1:0] wa [3];
    logic [RW-1:0] wd [3];
    wa[0] = 5'd3; wd[0] = 32'hA;
    wa[1] = 5'd4; wd[1] = 32'hB;
    wa[2] = 5'd3; wd[2] = 32'hC;
    r1_read_i = 1'b0;
    r2_read_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      w_enable_i = 1'b1;
      w_addr_i   = wa[i];
      w_data_i   = wd[i];
    end
    @(negedge clk);
    w_enable_i = 1'b0;
    r1_addr_i  = 5'd3;
    r2_addr_i  = 5'd4;
    r1_read_i  = 1'b1;
    r2_read_i  = 1'b1;
    #1;
    vectors++;
    if (r1_data_o !== 32'h0000_000C) begin
      miscompares++;
      $display("FAIL overwrite_r1 got %h exp %h", r1_data_o, 32'h0000_000C);
    end
    vectors++;
    if (r2_data_o !== 32'h0000_000B) begin
      miscompares++;
      $display("FAIL overwrite_r2 got %h exp %h", r2_data_o, 32'h0000_000B);
    end
    r1_read_i = 1'b0;
    #1;
    vectors++;
    if (r2_data_o !== 32'h0000_000B) begin
      miscompares++;
      $display("FAIL port_indep_r2 got %h exp %h", r2_data_o, 32'h0000_000B);
    end
  endtask

  task automatic test_async_reset();
    r1_read_i = 1'b0;
    r2_read_i = 1'b0;
    for (int a = 1; a < RN; a++) begin
      @(negedge clk);
      w_enable_i = 1'b1;
      w_addr_i   = AW'(a);
      w_data_i   = RW'(a);
    end
    @(negedge clk);
    w_enable_i = 1'b0;
    r1_addr_i  = 5'd31;
    r2_addr_i  = 5'd1;
    r1_read_i  = 1'b1;
    r2_read_i  = 1'b1;
    #1;
    vectors++;
    if (r1_data_o !== 32'd31) begin
      miscompares++;
      $display("FAIL load_x31 got %h exp %h", r1_data_o, 32'd31);
    end
    vectors++;
    if (r2_data_o !== 32'd1) begin
      miscompares++;
      $display("FAIL load_x1 got %h exp %h", r2_data_o, 32'd1);
    end
    #1;
    w_enable_i = 1'b1;
    w_addr_i   = 5'd12;
    w_data_i   = 32'h0000_ABCD;
    rst_n      = 1'b0;
    #1;
    vectors++;
    if (r1_data_o !== 32'h0) begin
      miscompares++;
      $display("FAIL async_r1_now got %h exp %h", r1_data_o, 32'h0);
    end
    vectors++;
    if (r2_data_o !== 32'h0) begin
      miscompares++;
      $display("FAIL async_r2_now got %h exp %h", r2_data_o, 32'h0);
    end
    @(negedge clk);
    w_enable_i = 1'b0;
    rst_n      = 1'b1;
    for (int a = 0; a < RN; a++) begin
      r1_addr_i = AW'(a);
      r2_addr_i = AW'(a);
      #1;
      vectors++;
      if (r1_data_o !== 32'h0) begin
        miscompares++;
        $display("FAIL post_reset_r1 addr=%0d got %h exp %h", a, r1_data_o, 32'h0);
      end
      vectors++;
      if (r2_data_o !== 32'h0) begin
        miscompares++;
        $display("FAIL post_reset_r2 addr=%0d got %h exp %h", a, r2_data_o, 32'h0);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    w_enable_i  = 1'b0;
    w_addr_i    = '0;
    w_data_i    = '0;
    r1_read_i   = 1'b0;
    r1_addr_i   = '0;
    r2_read_i   = 1'b0;
    r2_addr_i   = '0;
    test_reset();
    test_basic();
    test_x0();
    test_bypass();
    test_ports_overwrite();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
